count_arbiter: RTL and testbench

Sequencer and arbiter that shares one multi-cycle bit-count unit (`count_W8`: `a_in`, `sel`, `start` in; `done`, `cntout` out) between N requesters. It grants requesters round-robin, latches the winner's operand and mode, and pulses `start` to the count unit. It then waits for completion, with a timeout, and returns the count to the winner. It sits between client blocks and the single count unit instance.

---
 rtl/count_pkg.sv | 23 ++
 rtl/count_W8.sv | 57 +++++
 rtl/rr_pick.sv | 28 ++
 rtl/count_arbiter.sv | 136 +++++++++++++
 tb/tb_count_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// Shared types and constants for the count-unit arbiter and the count unit itself.
// Mode encodings, FSM state type and timer sizing helper.
package count_pkg;

    localparam logic [1:0] SEL_ZERO = 2'b01;
    localparam logic [1:0] SEL_ONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    function automatic int tmr_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    function automatic logic sel_valid(input logic [1:0] sel);
        return (sel == SEL_ZERO) || (sel == SEL_ONE);
    endfunction

endpackage

// File: rtl/count_W8.sv
// Multi-cycle bit-count unit: on start, counts ones (SEL_ONE) or zeros (SEL_ZERO)
// of the operand one bit per cycle; done rises after W cycles and holds until the next start.
module count_W8
    import count_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a_in,
    input  logic [1:0]   sel,
    input  logic         start,
    output logic         done,
    output logic [W-1:0] cntout
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sr;
    logic [1:0]    sel_q;
    logic [W-1:0]  cnt;
    logic [CW-1:0] bits;
    logic          running;
    logic          hit;

    assign hit    = ((sel_q == SEL_ONE) && sr[0]) || ((sel_q == SEL_ZERO) && !sr[0]);
    assign cntout = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            sel_q   <= '0;
            cnt     <= '0;
            bits    <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            sr      <= a_in;
            sel_q   <= sel;
            cnt     <= '0;
            bits    <= CW'(W);
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            if (hit) begin
                cnt <= cnt + W'(1);
            end
            sr   <= sr >> 1;
            bits <= bits - CW'(1);
            if (bits == CW'(1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner search: scans from last_grant+1 upward with wrap, first
// requester found wins. Purely combinational.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(last_grant) + k) % N);
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = idx;
            end
        end
    end

endmodule

// File: rtl/count_arbiter.sv
// Shares one count unit between N requesters: round-robin grant, single start
// pulse, wait for done edge with timeout, one-cycle response to the winner.
//
//   state | meaning
//   IDLE  | no operation; pick a winner when any req is high
//   ISSUE | one-cycle start pulse to the count unit, timer cleared
//   WAIT  | waiting for a done rising edge or timer expiry
//   RESP  | rsp_valid to winner, last_grant updated
module count_arbiter
    import count_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a_in,
    input  logic [2*N-1:0] req_sel,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_cnt,
    output logic           rsp_err,
    output logic           busy,
    output logic           cnt_start,
    output logic [W-1:0]   cnt_a_in,
    output logic [1:0]     cnt_sel,
    input  logic           cnt_done,
    input  logic [W-1:0]   cnt_cntout
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int TW  = tmr_width(TIMEOUT);

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] last_grant_q;
    logic [W-1:0]   a_q;
    logic [1:0]     sel_q;
    logic [W-1:0]   cnt_q;
    logic           err_q;
    logic [TW-1:0]  tmr_q;
    logic           done_q;

    logic [IDW-1:0] gnt_id;
    logic           any;
    logic [W-1:0]   gnt_a;
    logic [1:0]     gnt_sel;
    logic           done_edge;
    logic           tmr_expired;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_id     (gnt_id),
        .any        (any)
    );

    assign gnt_a       = req_a_in[gnt_id*W +: W];
    assign gnt_sel     = req_sel[gnt_id*2 +: 2];
    assign done_edge   = cnt_done & ~done_q;
    assign tmr_expired = (tmr_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any) state_nxt = sel_valid(gnt_sel) ? ISSUE : RESP;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (done_edge || tmr_expired) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done_q tracks cnt_done in every state so stale edges outside WAIT are absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q         <= '0;
            last_grant_q <= IDW'(N - 1);
            a_q          <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            tmr_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= cnt_done;
            case (state)
                IDLE: begin
                    if (any) begin
                        id_q  <= gnt_id;
                        a_q   <= gnt_a;
                        sel_q <= gnt_sel;
                        cnt_q <= '0;
                        err_q <= !sel_valid(gnt_sel);
                    end
                end
                ISSUE: tmr_q <= '0;
                WAIT: begin
                    if (done_edge) begin
                        cnt_q <= cnt_cntout;
                        err_q <= 1'b0;
                    end else if (tmr_expired) begin
                        cnt_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                RESP: last_grant_q <= id_q;
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign cnt_start = (state == ISSUE);
    assign cnt_a_in  = a_q;
    assign cnt_sel   = sel_q;
    assign rsp_valid = (state == RESP) ? (N'(1) << id_q) : '0;
    assign rsp_cnt   = (state == RESP) ? cnt_q : '0;
    assign rsp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter with the real count_W8 as the shared unit; a gate on
// done emulates a dead count unit for the timeout case.
module tb_count_arbiter;
    import count_pkg::*;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a_in;
    logic [2*N-1:0] req_sel;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_cnt;
    logic           rsp_err;
    logic           busy;
    logic           cnt_start;
    logic [W-1:0]   cnt_a_in;
    logic [1:0]     cnt_sel;
    logic           cnt_done;
    logic           done_raw;
    logic [W-1:0]   cnt_cntout;
    logic           stub_dead;

    assign cnt_done = done_raw & ~stub_dead;

    count_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_a_in   (req_a_in),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_cnt    (rsp_cnt),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .cnt_start  (cnt_start),
        .cnt_a_in   (cnt_a_in),
        .cnt_sel    (cnt_sel),
        .cnt_done   (cnt_done),
        .cnt_cntout (cnt_cntout)
    );

    count_W8 #(.W(W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .a_in   (cnt_a_in),
        .sel    (cnt_sel),
        .start  (cnt_start),
        .done   (done_raw),
        .cntout (cnt_cntout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int starts      = 0;
    int model_last  = N - 1;
    int order[$];
    logic [W-1:0] opnd [N];
    logic [1:0]   msel [N];

    always @(posedge clk) if (cnt_start === 1'b1) starts++;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [1:0]   sel;
        logic [W-1:0] exp_cnt;
        logic         exp_err;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_result(input logic [W-1:0] a, input logic [1:0] s,
                                       output logic [W-1:0] c, output logic e);
        if ((s == 2'b10 || s == 2'b01) && !stub_dead) begin
            e = 1'b0;
            c = (s == 2'b10) ? W'($countones(a)) : W'(W - $countones(a));
        end else begin
            e = 1'b1;
            c = '0;
        end
    endfunction

    function automatic int rr_model(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++)
            if (m[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic load(input int i, input logic [W-1:0] a, input logic [1:0] s);
        opnd[i] = a;
        msel[i] = s;
        req_a_in[i*W +: W] = a;
        req_sel[2*i +: 2]  = s;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == '0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last = N - 1;
    endtask

    // Holds every masked request until its response, dropping it the cycle after.
    task automatic serve(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        int cyc;
        int eid;
        logic [W-1:0] ec;
        logic ee;
        pend = mask;
        req  = mask;
        cyc  = 0;
        order.delete();
        while (pend != '0 && cyc < 100 * N) begin
            tick();
            cyc++;
            req = pend;
            if (rsp_valid != '0) begin
                eid = rr_model(pend, model_last);
                ref_result(opnd[eid], msel[eid], ec, ee);
                chk("rr_grant", 32'(rsp_valid), 32'(1) << eid);
                chk("rsp_cnt", 32'(rsp_cnt), 32'(ec));
                chk("rsp_err", 32'(rsp_err), 32'(ee));
                order.push_back(eid);
                model_last = eid;
                pend[eid] = 1'b0;
            end
        end
        chk("serve_all_done", 32'(pend), 0);
        tick();
        req = pend;
    endtask

    initial begin
        int n;
        int s0;
        logic [N-1:0] mask;
        logic [1:0] s;

        rst = 1'b1;
        req = '0;
        req_a_in = '0;
        req_sel = '0;
        stub_dead = 1'b0;
        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_cnt", 32'(rsp_cnt), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt_start", 32'(cnt_start), 0);
        chk("rst_cnt_a_in", 32'(cnt_a_in), 0);
        chk("rst_cnt_sel", 32'(cnt_sel), 0);
        rst = 1'b0;
        tick();

        tbl[0] = '{0, 8'b0000_1011, 2'b10, 8'd3, 1'b0};
        tbl[1] = '{2, 8'b0100_0010, 2'b01, 8'd6, 1'b0};
        tbl[2] = '{1, 8'h5A,        2'b11, 8'd0, 1'b1};
        tbl[3] = '{3, 8'hFF,        2'b10, 8'd8, 1'b0};
        tbl[4] = '{3, 8'hFF,        2'b01, 8'd0, 1'b0};
        tbl[5] = '{0, 8'h00,        2'b01, 8'd8, 1'b0};
        tbl[6] = '{1, 8'h00,        2'b00, 8'd0, 1'b1};
        tbl[7] = '{2, 8'hA5,        2'b10, 8'd4, 1'b0};
        tbl[8] = '{1, 8'h80,        2'b01, 8'd7, 1'b0};
        tbl[9] = '{0, 8'h00,        2'b10, 8'd0, 1'b0};

        for (int v = 0; v < 10; v++) begin
            req_a_in = 'x;
            req_sel  = 'x;
            load(tbl[v].id, tbl[v].a, tbl[v].sel);
            s0  = starts;
            req = N'(1) << tbl[v].id;
            wait_rsp(n);
            chk("tbl_valid", 32'(rsp_valid), 32'(1) << tbl[v].id);
            chk("tbl_cnt", 32'(rsp_cnt), 32'(tbl[v].exp_cnt));
            chk("tbl_err", 32'(rsp_err), 32'(tbl[v].exp_err));
            chk("tbl_latency", n, tbl[v].exp_err ? 1 : W + 3);
            chk("tbl_starts", starts - s0, tbl[v].exp_err ? 0 : 1);
            req = '0;
            model_last = tbl[v].id;
            tick();
        end
        req_a_in = '0;
        req_sel  = '0;

        // Operand goes X right after the grant; the latched copy must be used.
        load(2, 8'b0100_0010, 2'b01);
        req = 4'b0100;
        tick();
        req_a_in[2*W +: W] = 'x;
        tick();
        chk("x_cnt_a_hold", 32'(cnt_a_in), 32'h42);
        wait_rsp(n);
        chk("x_valid", 32'(rsp_valid), 32'h4);
        chk("x_cnt", 32'(rsp_cnt), 6);
        chk("x_no_unknown", 32'($isunknown({rsp_valid, rsp_cnt, rsp_err, busy,
                                              cnt_start, cnt_a_in, cnt_sel})), 0);
        req = '0;
        req_a_in[2*W +: W] = '0;
        tick();

        do_reset();
        for (int i = 0; i < N; i++) load(i, W'($urandom), (i % 2 == 0) ? 2'b10 : 2'b01);
        for (int r = 0; r < 2; r++) begin
            serve(4'b1111);
            chk("order_len", order.size(), N);
            for (int i = 0; i < order.size(); i++) chk("order_id", order[i], i);
        end

        // Dead count unit: timeout error, then normal service resumes.
        stub_dead = 1'b1;
        load(1, 8'hF0, 2'b10);
        req = 4'b0010;
        wait_rsp(n);
        chk("tmo_latency", n, TIMEOUT + 2);
        chk("tmo_valid", 32'(rsp_valid), 32'h2);
        chk("tmo_err", 32'(rsp_err), 1);
        chk("tmo_cnt", 32'(rsp_cnt), 0);
        req = '0;
        model_last = 1;
        tick();
        stub_dead = 1'b0;
        tick();
        serve(4'b0010);

        // Request withdrawn mid-operation is still answered.
        load(1, 8'h0F, 2'b01);
        req = 4'b0010;
        tick();
        tick();
        tick();
        req = '0;
        wait_rsp(n);
        chk("drop_valid", 32'(rsp_valid), 32'h2);
        chk("drop_cnt", 32'(rsp_cnt), 4);
        model_last = 1;
        tick();

        // Reset in the middle of WAIT.
        load(0, 8'hAA, 2'b10);
        req = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_busy_before", 32'(busy), 1);
        req = '0;
        rst = 1'b1;
        tick();
        chk("mid_rst_outs", 32'({rsp_valid, rsp_cnt, rsp_err, busy, cnt_start,
                                 cnt_a_in, cnt_sel}), 0);
        rst = 1'b0;
        model_last = N - 1;
        load(3, 8'h11, 2'b10);
        serve(4'b1000);
        chk("mid_req3_first", order.size() > 0 ? order[0] : -1, 3);
        do_reset();
        load(0, 8'h01, 2'b10);
        serve(4'b1001);
        chk("mid_req0_first", order.size() > 0 ? order[0] : -1, 0);

        for (int r = 0; r < 12; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) s = 2'($urandom_range(0, 3));
                else s = $urandom_range(0, 1) ? 2'b10 : 2'b01;
                load(i, W'($urandom), s);
            end
            serve(mask);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
